// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences CPU instruction-fetch and load/store requests onto the unified
//   code/data Memory port (addr / WR / IR_DR / MDataIn), waits out the
//   memory's one-cycle registered read latency, returns the fetched word or
//   load data with a one-cycle done pulse, range-checks every access against
//   the populated code/data depths and keeps saturating access counters.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   fetch_req, fetch_pc        instruction fetch request / word address
//   ls_req, ls_we, ls_addr,
//   ls_wdata                   load/store request, 1 = store, address, data
//   fetch_done, instr          fetch completion pulse / last fetched word
//   ls_done, ls_rdata          load/store completion pulse / last load data
//   addr_err                   accompanies a done pulse for out-of-range access
//   busy                       high whenever the sequencer is not idle
//   mem_addr, mem_WR,
//   mem_IR_DR, mem_MDataIn     Memory request side (WR = 0 writes)
//   mem_IR, mem_DR             Memory registered read data
//   fetch_cnt, load_cnt,
//   store_cnt                  saturating counts of in-range completions
module mem_access_ctrl #(
  parameter int CODE_DEPTH = 19,
  parameter int DATA_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_pc,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [31:0]      ls_addr,
  input  logic [31:0]      ls_wdata,
  output logic             fetch_done,
  output logic [31:0]      instr,
  output logic             ls_done,
  output logic [31:0]      ls_rdata,
  output logic             addr_err,
  output logic             busy,
  output logic [31:0]      mem_addr,
  output logic             mem_WR,
  output logic             mem_IR_DR,
  output logic [31:0]      mem_MDataIn,
  input  logic [31:0]      mem_IR,
  input  logic [31:0]      mem_DR,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    F_ISSUE = 3'd1,
    F_CAP   = 3'd2,
    L_ISSUE = 3'd3,
    L_CAP   = 3'd4,
    S_ISSUE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_reg, w_reg;
  logic        err_reg;
  logic [31:0] instr_reg, rdata_reg;
  logic        fetch_oor, ls_oor;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // Full 32-bit compare so high-order address bits can never alias into range.
  assign fetch_oor = (fetch_pc >= 32'(CODE_DEPTH));
  assign ls_oor    = (ls_addr  >= 32'(DATA_DEPTH));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; out-of-range accesses skip the issue cycle entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ls_req) begin
          if (ls_we) state_nxt = ls_oor ? S_DONE : S_ISSUE;
          else       state_nxt = ls_oor ? L_CAP  : L_ISSUE;
        end else if (fetch_req) begin
          state_nxt = fetch_oor ? F_CAP : F_ISSUE;
        end
      end
      F_ISSUE: state_nxt = F_CAP;
      F_CAP:   state_nxt = IDLE;
      L_ISSUE: state_nxt = L_CAP;
      L_CAP:   state_nxt = IDLE;
      S_ISSUE: state_nxt = S_DONE;
      S_DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, result holding registers and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      w_reg     <= '0;
      err_reg   <= 1'b0;
      instr_reg <= '0;
      rdata_reg <= '0;
      fetch_cnt <= '0;
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (ls_req) begin
          a_reg   <= ls_addr;
          w_reg   <= ls_wdata;
          err_reg <= ls_oor;
        end else if (fetch_req) begin
          a_reg   <= fetch_pc;
          err_reg <= fetch_oor;
        end
      end
      case (state)
        F_CAP: begin
          instr_reg <= err_reg ? 32'd0 : mem_IR;
          if (!err_reg) fetch_cnt <= sat_inc(fetch_cnt);
        end
        L_CAP: begin
          rdata_reg <= err_reg ? 32'd0 : mem_DR;
          if (!err_reg) load_cnt <= sat_inc(load_cnt);
        end
        S_DONE: begin
          if (!err_reg) store_cnt <= sat_inc(store_cnt);
        end
        default: ;
      endcase
    end
  end

  // Output logic. mem_WR defaults high so that only S_ISSUE can write; since
  // the state register resets asynchronously, reset releases WR immediately.
  // instr/ls_rdata bypass the capture register during the done cycle so the
  // result is valid together with the pulse.
  always_comb begin
    mem_addr    = '0;
    mem_WR      = 1'b1;
    mem_IR_DR   = 1'b0;
    mem_MDataIn = '0;
    fetch_done  = 1'b0;
    ls_done     = 1'b0;
    instr       = instr_reg;
    ls_rdata    = rdata_reg;
    case (state)
      F_ISSUE: mem_addr = a_reg;
      F_CAP: begin
        fetch_done = 1'b1;
        instr      = err_reg ? 32'd0 : mem_IR;
      end
      L_ISSUE: begin
        mem_addr  = a_reg;
        mem_IR_DR = 1'b1;
      end
      L_CAP: begin
        ls_done  = 1'b1;
        ls_rdata = err_reg ? 32'd0 : mem_DR;
      end
      S_ISSUE: begin
        mem_addr    = a_reg;
        mem_IR_DR   = 1'b1;
        mem_MDataIn = w_reg;
        mem_WR      = 1'b0;
      end
      S_DONE: ls_done = 1'b1;
      default: ;
    endcase
  end

  assign addr_err = err_reg & (fetch_done | ls_done);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int CODE_D = 19;
  localparam int DATA_D = 8;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req, ls_req, ls_we;
  logic [31:0]   fetch_pc, ls_addr, ls_wdata;
  logic          fetch_done, ls_done, addr_err, busy;
  logic [31:0]   instr, ls_rdata;
  logic [31:0]   mem_addr, mem_MDataIn, mem_IR, mem_DR;
  logic          mem_WR, mem_IR_DR;
  logic [CW-1:0] fetch_cnt, load_cnt, store_cnt;

  mem_access_ctrl #(.CODE_DEPTH(CODE_D), .DATA_DEPTH(DATA_D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .fetch_done(fetch_done), .instr(instr),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .addr_err(addr_err), .busy(busy),
    .mem_addr(mem_addr), .mem_WR(mem_WR), .mem_IR_DR(mem_IR_DR),
    .mem_MDataIn(mem_MDataIn), .mem_IR(mem_IR), .mem_DR(mem_DR),
    .fetch_cnt(fetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  // Memory block: one-cycle registered read, writes data whenever WR = 0.
  logic [31:0] code_mem  [0:CODE_D-1];
  logic [31:0] data_mem  [0:DATA_D-1];
  logic [31:0] data_init [0:DATA_D-1];
  logic        load_img;

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < DATA_D; i++) data_mem[i] <= data_init[i];
    end else if (mem_WR == 1'b0 && mem_addr < DATA_D) begin
      data_mem[mem_addr[2:0]] <= mem_MDataIn;
    end
    if (mem_IR_DR == 1'b0)
      mem_IR <= (mem_addr < CODE_D) ? code_mem[mem_addr[4:0]] : 32'hDEADBEEF;
    else
      mem_DR <= (mem_addr < DATA_D) ? data_mem[mem_addr[2:0]] : 32'hDEADBEEF;
  end

  // Reference model state: expected data contents, raw completion counts and
  // the last results the CPU should see.
  logic [31:0] data_ref [0:DATA_D-1];
  int          fc, lc, sc;
  logic [31:0] last_instr, last_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_dones"},     32'({fetch_done, ls_done, addr_err}), 32'd0);
    chk({tag, "_wr"},        32'(mem_WR), 32'd1);
    chk({tag, "_addr"},      mem_addr, 32'd0);
    chk({tag, "_ir_dr"},     32'(mem_IR_DR), 32'd0);
    chk({tag, "_mdatain"},   mem_MDataIn, 32'd0);
    chk({tag, "_instr"},     instr, last_instr);
    chk({tag, "_rdata"},     ls_rdata, last_rdata);
    chk({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'(sat(fc)));
    chk({tag, "_load_cnt"},  32'(load_cnt),  32'(sat(lc)));
    chk({tag, "_store_cnt"}, 32'(store_cnt), 32'(sat(sc)));
  endtask

  // kind: 0 fetch, 1 load, 2 store. Called and returns at a falling edge
  // in an idle cycle. dual raises fetch_req alongside a load/store.
  task automatic do_access(input int kind, input logic [31:0] a,
                           input logic [31:0] wd, input bit dual);
    bit oor;
    oor       = (kind == 0) ? (a >= CODE_D) : (a >= DATA_D);
    fetch_req = (kind == 0) || dual;
    fetch_pc  = (kind == 0) ? a : $urandom;
    ls_req    = (kind != 0);
    ls_we     = (kind == 2);
    ls_addr   = (kind != 0) ? a : $urandom;
    ls_wdata  = wd;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    ls_req    = 1'b0;
    fetch_pc  = $urandom;
    ls_addr   = $urandom;
    ls_wdata  = $urandom;
    ls_we     = 1'($urandom);
    if (!oor) begin
      @(negedge clk);
      chk("issue_busy", 32'(busy), 32'd1);
      chk("issue_addr", mem_addr, a);
      chk("issue_wr", 32'(mem_WR), (kind == 2) ? 32'd0 : 32'd1);
      if (kind == 2) chk("issue_wdata", mem_MDataIn, wd);
      else           chk("issue_ir_dr", 32'(mem_IR_DR), (kind == 1) ? 32'd1 : 32'd0);
      chk("issue_dones", 32'({fetch_done, ls_done, addr_err}), 32'd0);
    end
    @(negedge clk);
    chk("done_fetch", 32'(fetch_done), 32'(kind == 0));
    chk("done_ls",    32'(ls_done),    32'(kind != 0));
    chk("done_err",   32'(addr_err),   32'(oor));
    chk("done_wr",    32'(mem_WR),     32'd1);
    chk("done_busy",  32'(busy),       32'd1);
    if (kind == 0) begin
      last_instr = oor ? 32'd0 : code_mem[a[4:0]];
      chk("done_instr", instr, last_instr);
      if (!oor) fc++;
    end else if (kind == 1) begin
      last_rdata = oor ? 32'd0 : data_ref[a[2:0]];
      chk("done_rdata", ls_rdata, last_rdata);
      if (!oor) lc++;
    end else if (!oor) begin
      data_ref[a[2:0]] = wd;
      sc++;
    end
    @(negedge clk);
    check_idle("after");
    if (dual) begin
      @(negedge clk);
      chk("lost_fetch_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    fc = 0; lc = 0; sc = 0;
    last_instr = '0;
    last_rdata = '0;
    check_idle("reset_async");
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; load_img = 1'b1;
    fetch_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    fetch_pc = '0; ls_addr = '0; ls_wdata = '0;
    for (int i = 0; i < CODE_D; i++) code_mem[i] = $urandom;
    code_mem[1] = 32'h8C200003;
    for (int i = 0; i < DATA_D; i++) data_init[i] = $urandom;
    data_init[3] = 32'h000000AC;
    for (int i = 0; i < DATA_D; i++) data_ref[i] = data_init[i];
    @(posedge clk); @(posedge clk); #1;
    load_img = 1'b0;
    @(negedge clk);
    do_reset();

    // Fetch from address 1
    do_access(0, 32'd1, 32'd0, 1'b0);
    chk("tp_instr", instr, 32'h8C200003);
    chk("tp_fetch_cnt", 32'(fetch_cnt), 32'd1);

    // Store 0xAC to 5, then load it back
    do_access(2, 32'd5, 32'h000000AC, 1'b0);
    do_access(1, 32'd5, 32'd0, 1'b0);
    chk("tp_rdata", ls_rdata, 32'h000000AC);
    chk("tp_store_cnt", 32'(store_cnt), 32'd1);
    chk("tp_load_cnt", 32'(load_cnt), 32'd1);

    // Simultaneous load (addr 3) and fetch (pc 2), fetch held high
    fetch_req = 1'b1; fetch_pc = 32'd2;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd3;
    @(posedge clk); #1;
    ls_req = 1'b0; ls_addr = $urandom;
    @(negedge clk);
    chk("sim_issue_ir_dr", 32'(mem_IR_DR), 32'd1);
    chk("sim_issue_addr", mem_addr, 32'd3);
    @(negedge clk);
    chk("sim_ls_done", 32'(ls_done), 32'd1);
    chk("sim_fetch_done", 32'(fetch_done), 32'd0);
    chk("sim_rdata", ls_rdata, 32'h000000AC);
    last_rdata = data_ref[3];
    lc++;
    @(negedge clk);
    chk("sim_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    fetch_req = 1'b0; fetch_pc = $urandom;
    @(negedge clk);
    chk("sim_f_busy", 32'(busy), 32'd1);
    chk("sim_f_ir_dr", 32'(mem_IR_DR), 32'd0);
    chk("sim_f_addr", mem_addr, 32'd2);
    @(negedge clk);
    chk("sim_f_done", 32'(fetch_done), 32'd1);
    last_instr = code_mem[2];
    chk("sim_f_instr", instr, last_instr);
    fc++;
    @(negedge clk);
    check_idle("sim_after");

    // Losing fetch request is dropped
    do_access(1, 32'd4, 32'd0, 1'b1);

    // Out-of-range accesses, including boundaries and high address bits
    do_access(0, 32'd19, 32'd0, 1'b0);
    do_access(2, 32'd8, 32'h12345678, 1'b0);
    do_access(1, 32'd8, 32'd0, 1'b0);
    do_access(0, 32'h80000001, 32'd0, 1'b0);
    do_access(2, 32'h00010005, 32'hCAFEF00D, 1'b0);
    do_access(0, 32'd18, 32'd0, 1'b0);
    do_access(1, 32'd7, 32'd0, 1'b0);

    // Reset asserted during the store write cycle
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd6; ls_wdata = 32'h000055AA;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk);
    chk("abort_wr_low", 32'(mem_WR), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("abort_wr", 32'(mem_WR), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ls_done", 32'(ls_done), 32'd0);
    chk("abort_store_cnt", 32'(store_cnt), 32'd0);
    fc = 0; lc = 0; sc = 0;
    last_instr = '0;
    last_rdata = '0;
    @(negedge clk);
    chk("abort_ls_done2", 32'(ls_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_idle("abort_after");
    do_access(1, 32'd6, 32'd0, 1'b0);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) do_access(0, 32'($urandom_range(0, CODE_D - 1)), 32'd0, 1'b0);
    chk("sat_fetch_cnt", 32'(fetch_cnt), 32'd3);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int kind, r, depth;
      logic [31:0] a;
      kind  = $urandom_range(0, 2);
      depth = (kind == 0) ? CODE_D : DATA_D;
      r     = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, depth - 1));
      else if (r == 7) a = 32'(depth);
      else if (r == 8) a = 32'(depth - 1);
      else             a = $urandom | 32'h00000100;
      do_access(kind, a, $urandom, (kind != 0) && ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
